// File: rtl/alu_nzcv_seq.sv
// rtl/alu_nzcv_seq.sv - sequential N-bit ALU with registered y/nzcv and a done pulse
// Define ALU_NZCV_MUL_EN to build in the MULT state and its shift-add multiplier.
module alu_nzcv_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y,
   output logic [3:0]   nzcv,
   output logic         busy,
   output logic         done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_ADC = 3'b100;
   localparam logic [2:0] OP_SBC = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MULT} state_t;

   state_t       state_q;
   logic [2:0]   op_q;
   logic [N-1:0] a_q, b_q;
   logic         c_q;
   logic [N-1:0] y_q;
   logic [3:0]   nzcv_q;
   logic         done_q;

   logic         sub;
   logic         cin;
   logic [N-1:0] bop;
   logic [N:0]   sum;
   logic [N-1:0] res_y;
   logic         res_c, res_v;

   // Subtraction is a + ~b + cin, so the carry-out is directly the "no borrow" flag.
   always_comb begin
      sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
      bop   = sub ? ~b_q : b_q;
      cin   = 1'b0;
      case (op_q)
         OP_SUB, OP_CMP: cin = 1'b1;
         OP_ADC, OP_SBC: cin = c_q;
         default:        cin = 1'b0;
      endcase
      sum   = {1'b0, a_q} + {1'b0, bop} + {{N{1'b0}}, cin};
      res_y = sum[N-1:0];
      res_c = sum[N];
      res_v = (a_q[N-1] == bop[N-1]) && (sum[N-1] != a_q[N-1]);
      case (op_q)
         OP_AND: begin res_y = a_q & b_q; res_c = 1'b0; res_v = 1'b0; end
         OP_OR:  begin res_y = a_q | b_q; res_c = 1'b0; res_v = 1'b0; end
         default: ;
      endcase
   end

`ifdef ALU_NZCV_MUL_EN
   localparam int CW = $clog2(N);
   logic [CW-1:0]  cnt_q;
   logic [2*N-1:0] prod_q, prod_d;

   always_comb begin
      prod_d = prod_q;
      if (b_q[cnt_q])
         prod_d = prod_q + ({{N{1'b0}}, a_q} << cnt_q);
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         y_q     <= '0;
         nzcv_q  <= '0;
         done_q  <= 1'b0;
`ifdef ALU_NZCV_MUL_EN
         cnt_q   <= '0;
         prod_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  c_q  <= nzcv_q[1];
`ifdef ALU_NZCV_MUL_EN
                  if (op == OP_MUL) begin
                     state_q <= S_MULT;
                     cnt_q   <= '0;
                     prod_q  <= '0;
                  end else begin
                     state_q <= S_EXEC;
                  end
`else
                  state_q <= S_EXEC;
`endif
               end
            end
            S_EXEC: begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
               if (op_q != OP_MUL) begin
                  if (op_q != OP_CMP)
                     y_q <= res_y;
                  nzcv_q <= {res_y[N-1], (res_y == '0), res_c, res_v};
               end
            end
`ifdef ALU_NZCV_MUL_EN
            S_MULT: begin
               if (cnt_q == CW'(N-1)) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
                  y_q     <= prod_d[N-1:0];
                  nzcv_q  <= {prod_d[N-1], (prod_d[N-1:0] == '0), (|prod_d[2*N-1:N]), 1'b0};
               end else begin
                  prod_q <= prod_d;
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y    = y_q;
   assign nzcv = nzcv_q;
   assign busy = (state_q != S_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_alu_nzcv_seq.sv
// tb/tb_alu_nzcv_seq.sv - randomized and directed bench for alu_nzcv_seq against an integer reference model
// Expectations follow ALU_NZCV_MUL_EN when the bench is built with it.
module tb_alu_nzcv_seq;

   localparam int N = 4;
   localparam int M = 1 << N;
`ifdef ALU_NZCV_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, start;
   logic [2:0]   op;
   logic [N-1:0] a, b, y;
   logic [3:0]   nzcv;
   logic         busy, done;

   int n_vec = 0;
   int n_err = 0;
   int m_y   = 0;
   int m_f   = 0;

   always #5 clk = ~clk;

   alu_nzcv_seq #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .y(y), .nzcv(nzcv), .busy(busy), .done(done)
   );

   function automatic int sgn(input int v);
      return (v >= M/2) ? v - M : v;
   endfunction

   task automatic model(input int o, input int av, input int bv);
      int r, sr, c, v, cs, yv, nf, zf;
      cs = (m_f >> 1) & 1;
      r = 0; sr = 0; c = 0; v = 0;
      case (o)
         0: begin r = av + bv;          sr = sgn(av) + sgn(bv);          c = (r >= M); end
         4: begin r = av + bv + cs;     sr = sgn(av) + sgn(bv) + cs;     c = (r >= M); end
         1, 7: begin r = av - bv;       sr = sgn(av) - sgn(bv);          c = (r >= 0); end
         5: begin r = av - bv - 1 + cs; sr = sgn(av) - sgn(bv) - 1 + cs; c = (r >= 0); end
         2: r = av & bv;
         3: r = av | bv;
         default: begin r = av * bv; c = (r >= M); end
      endcase
      if (o == 0 || o == 4 || o == 1 || o == 7 || o == 5)
         v = (sr > M/2 - 1 || sr < -(M/2)) ? 1 : 0;
      if (o == 6 && !MUL_EN) return;
      yv = ((r % M) + M) % M;
      nf = (yv >= M/2) ? 1 : 0;
      zf = (yv == 0) ? 1 : 0;
      if (o != 7) m_y = yv;
      m_f = (nf << 3) | (zf << 2) | (c << 1) | v;
   endtask

   // Starts the op in the current cycle and returns in the done cycle, so consecutive calls are back-to-back.
   task automatic run_op(input int o, input int av, input int bv, input bit junk);
      int lat, k;
      lat = (o == 6 && MUL_EN) ? N + 1 : 2;
      op = 3'(o); a = N'(av); b = N'(bv); start = 1'b1;
      model(o, av, bv);
      k = 0;
      while (k < 30) begin
         k++;
         @(posedge clk); #1;
         if (k == 1) begin
            n_vec++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL busy_after_accept op=%0d got=%b want=1", o, busy);
            end
            if (junk) begin
               op = 3'($urandom); a = N'($urandom); b = N'($urandom);
            end else begin
               start = 1'b0;
            end
         end else if (k == 2) begin
            start = 1'b0;
         end
         if (done === 1'b1) break;
      end
      n_vec++;
      if (k != lat) begin
         n_err++;
         $display("FAIL latency op=%0d a=%0d b=%0d got=%0d want=%0d", o, av, bv, k, lat);
      end
      n_vec++;
      if (y !== N'(m_y)) begin
         n_err++;
         $display("FAIL y op=%0d a=%0d b=%0d got=%0d want=%0d", o, av, bv, y, m_y);
      end
      n_vec++;
      if (nzcv !== 4'(m_f)) begin
         n_err++;
         $display("FAIL nzcv op=%0d a=%0d b=%0d got=%b want=%b", o, av, bv, nzcv, 4'(m_f));
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_at_done op=%0d got=%b want=0", o, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; op = 3'b000; a = 4'd7; b = 4'd7;
      repeat (2) @(posedge clk);
      #1;
      m_y = 0; m_f = 0;
      n_vec++; if (y !== 4'd0)    begin n_err++; $display("FAIL reset_y got=%b want=0000", y); end
      n_vec++; if (nzcv !== 4'd0) begin n_err++; $display("FAIL reset_nzcv got=%b want=0000", nzcv); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      reset = 1'b0; start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_op(0, 4, 4, 1'b0);
      n_vec++; if ({y, nzcv} !== 8'b1000_1001) begin n_err++; $display("FAIL add_4_4 got=%b_%b want=1000_1001", y, nzcv); end
      run_op(0, 15, 1, 1'b0);
      n_vec++; if ({y, nzcv} !== 8'b0000_0110) begin n_err++; $display("FAIL add_15_1 got=%b_%b want=0000_0110", y, nzcv); end
      run_op(4, 2, 3, 1'b0);
      n_vec++; if ({y, nzcv} !== 8'b0110_0000) begin n_err++; $display("FAIL adc_2_3 got=%b_%b want=0110_0000", y, nzcv); end
      run_op(1, 3, 13, 1'b0);
      n_vec++; if ({y, nzcv} !== 8'b0110_0000) begin n_err++; $display("FAIL sub_3_13 got=%b_%b want=0110_0000", y, nzcv); end
      run_op(6, 5, 3, 1'b0);
      run_op(6, 6, 6, 1'b0);
      run_op(7, 5, 5, 1'b0);
      n_vec++; if (nzcv !== 4'b0110) begin n_err++; $display("FAIL cmp_5_5 got=%b want=0110", nzcv); end
      run_op(2, 12, 10, 1'b0);
      run_op(3, 0, 0, 1'b0);
      run_op(5, 8, 1, 1'b0);
   endtask

   task automatic test_busy_ignore();
      run_op(6, 5, 3, 1'b1);
      run_op(6, 15, 15, 1'b1);
      run_op(0, 7, 2, 1'b1);
   endtask

   task automatic test_done_pulse();
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b want=0", done); end
      n_vec++; if (y !== N'(m_y)) begin n_err++; $display("FAIL y_hold got=%0d want=%0d", y, m_y); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (nzcv !== 4'(m_f)) begin n_err++; $display("FAIL nzcv_hold got=%b want=%b", nzcv, 4'(m_f)); end
   endtask

   task automatic test_reset_abort(input int o);
      int seen;
      run_op(0, 9, 9, 1'b0);
      op = 3'(o); a = 4'd5; b = 4'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_y = 0; m_f = 0;
      n_vec++; if (y !== 4'd0)    begin n_err++; $display("FAIL abort_y op=%0d got=%b want=0000", o, y); end
      n_vec++; if (nzcv !== 4'd0) begin n_err++; $display("FAIL abort_nzcv op=%0d got=%b want=0000", o, nzcv); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy op=%0d got=%b want=0", o, busy); end
      seen = (done === 1'b1) ? 1 : 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1;
      end
      n_vec++; if (seen != 0) begin n_err++; $display("FAIL abort_no_done op=%0d got=1 want=0", o); end
   endtask

   task automatic test_random_back_to_back();
      for (int i = 0; i < 60; i++)
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, M-1)),
                int'($urandom_range(0, M-1)), bit'($urandom_range(0, 1)));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      test_reset();
      test_directed();
      test_busy_ignore();
      test_done_pulse();
      test_reset_abort(6);
      test_reset_abort(0);
      test_random_back_to_back();
      test_done_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
